// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch slot: op encoding, predictor counters
// and the ID/EX control record.
package branch_pkg;

    typedef enum logic [1:0] {
        OpBeq = 2'd0,
        OpBne = 2'd1,
        OpBlt = 2'd2,
        OpBge = 2'd3
    } br_op_e;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_INIT_DEFAULT = 2'b01;

    typedef struct packed {
        logic   is_nop;
        logic   is_jmp;
        logic   is_imm_type;
        logic   zero_ext;
        br_op_e op;
        logic   [4:0] rs1;
        logic   [4:0] rs2;
        logic   [4:0] rd;
        logic   pred_taken;
    } idex_ctl_t;

    localparam idex_ctl_t IDEX_NOP = '{
        is_nop:      1'b1,
        is_jmp:      1'b0,
        is_imm_type: 1'b0,
        zero_ext:    1'b0,
        op:          OpBeq,
        rs1:         5'd0,
        rs2:         5'd0,
        rd:          5'd0,
        pred_taken:  1'b0
    };

    function automatic ctr_t sat_inc(ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t sat_dec(ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_decode.sv
// Branch-slot instruction decode: [31:30] class (01 branch, 10 jump, else nop),
// [29] imm-type, [28] zero_ext, [27:26] op, [25:21]/[20:16] registers, [15:0] imm.
module branch_decode
    import branch_pkg::*;
#(
    parameter int unsigned IMM_W = 22
) (
    input  logic [31:0]      inst_i,
    output logic             is_nop_o,
    output logic             is_jmp_o,
    output logic             is_imm_type_o,
    output logic             zero_ext_o,
    output br_op_e           op_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [IMM_W-1:0] imm_o
);

    logic is_br;
    logic is_jmp;

    assign is_br  = (inst_i[31:30] == 2'b01);
    assign is_jmp = (inst_i[31:30] == 2'b10);

    always_comb begin
        is_nop_o      = !(is_br || is_jmp);
        is_jmp_o      = is_jmp;
        is_imm_type_o = 1'b0;
        zero_ext_o    = 1'b0;
        op_o          = OpBeq;
        rs1_o         = 5'd0;
        rs2_o         = 5'd0;
        rd_o          = 5'd0;
        imm_o         = '0;
        if (is_br || is_jmp) begin
            is_imm_type_o = inst_i[29];
            zero_ext_o    = inst_i[28];
            op_o          = br_op_e'(inst_i[27:26]);
            imm_o         = {{(IMM_W-16){inst_i[15] & ~inst_i[28]}}, inst_i[15:0]};
            // Jumps carry the link register first; branches carry both sources.
            if (is_jmp) begin
                rd_o  = inst_i[25:21];
                rs1_o = inst_i[20:16];
            end else begin
                rs1_o = inst_i[25:21];
                rs2_o = inst_i[20:16];
            end
        end
    end

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read port,
// one update port applied at the clock edge. Reads see the pre-update value.
module branch_pred_table
    import branch_pkg::*;
#(
    parameter int unsigned Depth   = 64,
    parameter ctr_t        CtrInit = CTR_INIT_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(Depth)-1:0] rd_idx_i,
    output ctr_t                     rd_ctr_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_idx_i,
    input  logic                     wr_taken_i
);

    ctr_t ctr_q [Depth];
    ctr_t wr_ctr_d;

    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        wr_ctr_d = wr_taken_i ? sat_inc(ctr_q[wr_idx_i]) : sat_dec(ctr_q[wr_idx_i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                ctr_q[i] <= CtrInit;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch slot: decode-time prediction from the counter table, ID/EX register,
// and execute-time resolution with mispredict redirect and link write.
module branch_pred_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMM_W      = 22,
    parameter int unsigned PRED_DEPTH = 64,
    parameter ctr_t        CTR_INIT   = CTR_INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] inst_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_pc,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] ret_addr,
    output logic            reg_file_wr_en,
    output logic            mispredict,
    output logic [XLEN-1:0] new_pc
);

    localparam int unsigned IDX_W = $clog2(PRED_DEPTH);

    logic             d_is_nop;
    logic             d_is_jmp;
    logic             d_is_imm_type;
    logic             d_zero_ext;
    br_op_e           d_op;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic [4:0]       d_rd;
    logic [IMM_W-1:0] d_imm;
    logic [XLEN-1:0]  imm_ext;
    ctr_t             rd_ctr;

    idex_ctl_t        idex_q, idex_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pred_pc_q, pred_pc_d;

    logic             ex_valid;
    logic             cond_taken;
    logic             actual_taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  pc_plus4;

    branch_decode #(
        .IMM_W (IMM_W)
    ) u_decode (
        .inst_i        (inst),
        .is_nop_o      (d_is_nop),
        .is_jmp_o      (d_is_jmp),
        .is_imm_type_o (d_is_imm_type),
        .zero_ext_o    (d_zero_ext),
        .op_o          (d_op),
        .rs1_o         (d_rs1),
        .rs2_o         (d_rs2),
        .rd_o          (d_rd),
        .imm_o         (d_imm)
    );

    branch_pred_table #(
        .Depth   (PRED_DEPTH),
        .CtrInit (CTR_INIT)
    ) u_table (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (inst_pc[IDX_W+1:2]),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (ex_valid && !idex_q.is_jmp),
        .wr_idx_i   (pc_q[IDX_W+1:2]),
        .wr_taken_i (cond_taken)
    );

    // Decode-stage prediction
    assign imm_ext    = {{(XLEN-IMM_W){d_imm[IMM_W-1] & ~d_zero_ext}}, d_imm};
    assign pred_pc    = inst_pc + imm_ext;
    assign pred_taken = !rst && !d_is_nop && d_is_imm_type && (d_is_jmp || rd_ctr[1]);

    // The wrong-path slot behind a mispredict is squashed like an external flush.
    always_comb begin
        idex_d    = idex_q;
        pc_d      = pc_q;
        pred_pc_d = pred_pc_q;
        if (!stall) begin
            if (flush || mispredict) begin
                idex_d    = IDEX_NOP;
                pc_d      = '0;
                pred_pc_d = '0;
            end else begin
                idex_d = '{
                    is_nop:      d_is_nop,
                    is_jmp:      d_is_jmp,
                    is_imm_type: d_is_imm_type,
                    zero_ext:    d_zero_ext,
                    op:          d_op,
                    rs1:         d_rs1,
                    rs2:         d_rs2,
                    rd:          d_rd,
                    pred_taken:  pred_taken
                };
                pc_d      = inst_pc;
                pred_pc_d = pred_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q    <= IDEX_NOP;
            pc_q      <= '0;
            pred_pc_q <= '0;
        end else begin
            idex_q    <= idex_d;
            pc_q      <= pc_d;
            pred_pc_q <= pred_pc_d;
        end
    end

    // Execute-stage resolution
    always_comb begin
        cond_taken = 1'b0;
        case (idex_q.op)
            OpBeq: cond_taken = (rs1_data == rs2_data);
            OpBne: cond_taken = (rs1_data != rs2_data);
            OpBlt: cond_taken = idex_q.zero_ext ? (rs1_data < rs2_data)
                                                : ($signed(rs1_data) < $signed(rs2_data));
            OpBge: cond_taken = idex_q.zero_ext ? (rs1_data >= rs2_data)
                                                : ($signed(rs1_data) >= $signed(rs2_data));
        endcase
    end

    assign ex_valid     = !rst && !stall && !idex_q.is_nop;
    assign actual_taken = idex_q.is_jmp || cond_taken;
    // For imm-type the resolved target equals the decode-time pc + ext(imm).
    assign target       = idex_q.is_imm_type ? pred_pc_q : rs1_data;
    assign pc_plus4     = pc_q + XLEN'(4);

    assign mispredict = ex_valid &&
                        ((actual_taken != idex_q.pred_taken) ||
                         (actual_taken && (target != pred_pc_q)));
    assign new_pc         = actual_taken ? target : pc_plus4;
    assign ret_addr       = pc_plus4;
    assign reg_file_wr_en = ex_valid && idex_q.is_jmp && (idex_q.rd != 5'd0);

    assign rs1_out = idex_q.rs1;
    assign rs2_out = idex_q.rs2;
    assign rd_out  = idex_q.rd;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_pred_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] inst, inst_pc, rs1_data, rs2_data;
    logic        pred_taken, reg_file_wr_en, mispredict;
    logic [31:0] pred_pc, ret_addr, new_pc;
    logic [4:0]  rs1_out, rs2_out, rd_out;

    always #5 clk = ~clk;

    branch_pred_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rd_out         (rd_out),
        .ret_addr       (ret_addr),
        .reg_file_wr_en (reg_file_wr_en),
        .mispredict     (mispredict),
        .new_pc         (new_pc)
    );

    // kind: 0 nop, 1 conditional branch, 2 jump
    typedef struct {
        int        kind;
        bit        immt;
        bit        zext;
        bit [1:0]  op;
        bit [4:0]  a;
        bit [4:0]  b;
        bit [15:0] imm;
    } ins_t;

    int        ctr [DEPTH];
    bit        sv;
    ins_t      sx;
    bit [31:0] spc;
    bit        spred;
    bit        known;
    int        n_checks;
    int        n_errors;

    function automatic ins_t mk(int kind, bit immt, bit zext, bit [1:0] op,
                                bit [4:0] a, bit [4:0] b, bit [15:0] imm);
        ins_t x;
        x.kind = kind; x.immt = immt; x.zext = zext; x.op = op;
        x.a = a; x.b = b; x.imm = imm;
        return x;
    endfunction

    function automatic logic [31:0] enc(ins_t x);
        bit [1:0] cls;
        cls = (x.kind == 1) ? 2'b01 : (x.kind == 2) ? 2'b10 : 2'b00;
        return {cls, x.immt, x.zext, x.op, x.a, x.b, x.imm};
    endfunction

    function automatic bit [31:0] ext(ins_t x);
        if (x.zext) return {16'h0, x.imm};
        return {{16{x.imm[15]}}, x.imm};
    endfunction

    function automatic int idx(bit [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit resolve(ins_t x, bit [31:0] d1, bit [31:0] d2);
        if (x.kind == 2) return 1'b1;
        case (x.op)
            2'd0: return d1 == d2;
            2'd1: return d1 != d2;
            2'd2: return x.zext ? (d1 < d2) : ($signed(d1) < $signed(d2));
            default: return x.zext ? (d1 >= d2) : ($signed(d1) >= $signed(d2));
        endcase
    endfunction

    function automatic bit [4:0] f_rs1(ins_t x);
        return (x.kind == 1) ? x.a : (x.kind == 2) ? x.b : 5'd0;
    endfunction
    function automatic bit [4:0] f_rs2(ins_t x);
        return (x.kind == 1) ? x.b : 5'd0;
    endfunction
    function automatic bit [4:0] f_rd(ins_t x);
        return (x.kind == 2) ? x.a : 5'd0;
    endfunction

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model.
    task automatic step(bit r, bit s, bit f, ins_t x, bit [31:0] pc,
                        bit [31:0] d1, bit [31:0] d2);
        bit        pt, act, tk, mis;
        bit [31:0] tgt, ptgt;
        @(negedge clk);
        rst = r; stall = s; flush = f; inst = enc(x); inst_pc = pc;
        rs1_data = d1; rs2_data = d2;
        #2;
        pt = !r && (x.kind != 0) && x.immt && ((x.kind == 2) || (ctr[idx(pc)] >= 2));
        chk1("pred_taken", pred_taken, pt);
        if (pt) chk32("pred_pc", pred_pc, pc + ext(x));
        act  = !r && !s && sv;
        tk   = sv && resolve(sx, d1, d2);
        ptgt = spc + ext(sx);
        tgt  = sx.immt ? ptgt : d1;
        mis  = act && !((tk == spred) && (!tk || tgt == ptgt));
        if (known) begin
            chk32("rs1_out", {27'b0, rs1_out}, {27'b0, sv ? f_rs1(sx) : 5'd0});
            chk32("rs2_out", {27'b0, rs2_out}, {27'b0, sv ? f_rs2(sx) : 5'd0});
            chk32("rd_out", {27'b0, rd_out}, {27'b0, sv ? f_rd(sx) : 5'd0});
            chk1("mispredict", mispredict, mis);
            if (mis) chk32("new_pc", new_pc, tk ? tgt : spc + 32'd4);
            chk1("wr_en", reg_file_wr_en, act && (sx.kind == 2) && (f_rd(sx) != 5'd0));
            if (sv) chk32("ret_addr", ret_addr, spc + 32'd4);
        end
        if (r) begin
            foreach (ctr[i]) ctr[i] = 1;
            sv    = 1'b0;
            known = 1'b1;
        end else if (!s) begin
            if (act && sx.kind == 1) begin
                if (tk) ctr[idx(spc)] = (ctr[idx(spc)] == 3) ? 3 : ctr[idx(spc)] + 1;
                else    ctr[idx(spc)] = (ctr[idx(spc)] == 0) ? 0 : ctr[idx(spc)] - 1;
            end
            sv    = !(f || mis) && (x.kind != 0);
            sx    = x;
            spc   = pc;
            spred = pt;
        end
    endtask

    function automatic bit [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h5;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        ins_t nop_i, beq, bne, jal1, jal0, jal2, jr, blt, bltu, beq5, rx;
        bit [31:0] rpc, d1, d2;
        int  kr;
        n_checks = 0; n_errors = 0; known = 1'b0; sv = 1'b0;
        foreach (ctr[i]) ctr[i] = 1;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; inst = '0; inst_pc = '0;
        rs1_data = '0; rs2_data = '0;

        nop_i = mk(0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 16'h0);
        beq   = mk(1, 1'b1, 1'b0, 2'd0, 5'd1, 5'd2, 16'h20);
        bne   = mk(1, 1'b1, 1'b0, 2'd1, 5'd1, 5'd2, 16'h20);
        jal1  = mk(2, 1'b1, 1'b0, 2'd0, 5'd1, 5'd0, 16'h40);
        jal0  = mk(2, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 16'h40);
        jal2  = mk(2, 1'b1, 1'b0, 2'd0, 5'd2, 5'd0, 16'h10);
        jr    = mk(2, 1'b0, 1'b0, 2'd0, 5'd0, 5'd3, 16'h0);
        blt   = mk(1, 1'b1, 1'b0, 2'd2, 5'd1, 5'd2, 16'h10);
        bltu  = mk(1, 1'b1, 1'b1, 2'd2, 5'd1, 5'd2, 16'h10);
        beq5  = mk(1, 1'b1, 1'b0, 2'd0, 5'd1, 5'd2, 16'h8);

        step(1'b1, 1'b0, 1'b0, nop_i, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, nop_i, 32'h0, 32'h0, 32'h0);
        chk1("rst_mispredict", mispredict, 1'b0);
        chk32("rst_rd_out", {27'b0, rd_out}, 32'h0);

        // Weakly-not-taken BEQ mispredicts, then trains to strongly taken.
        step(1'b0, 1'b0, 1'b0, beq, 32'h100, 32'h0, 32'h0);
        chk1("beq_pred0", pred_taken, 1'b0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h5, 32'h5);
        chk1("beq_mis", mispredict, 1'b1);
        chk32("beq_newpc", new_pc, 32'h120);
        step(1'b0, 1'b0, 1'b0, beq, 32'h100, 32'h0, 32'h0);
        chk1("beq_pred_c2", pred_taken, 1'b1);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h5, 32'h5);
        chk1("beq_hit", mispredict, 1'b0);
        step(1'b0, 1'b0, 1'b0, beq, 32'h100, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h5, 32'h5);
        step(1'b0, 1'b0, 1'b0, beq, 32'h100, 32'h0, 32'h0);
        chk1("beq_pred_c3", pred_taken, 1'b1);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h5, 32'h6);
        chk1("beq_nt_mis", mispredict, 1'b1);
        chk32("beq_nt_newpc", new_pc, 32'h104);
        // Counter now 2 (was 3): BNE with equal operands mispredicts.
        step(1'b0, 1'b0, 1'b0, bne, 32'h100, 32'h0, 32'h0);
        chk1("bne_pred_c2", pred_taken, 1'b1);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h7, 32'h7);
        chk1("bne_mis", mispredict, 1'b1);
        chk32("bne_newpc", new_pc, 32'h104);
        step(1'b0, 1'b0, 1'b0, beq, 32'h100, 32'h0, 32'h0);
        chk1("beq_pred_c1", pred_taken, 1'b0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h1, 32'h2);
        chk1("beq_nt_hit", mispredict, 1'b0);

        // Immediate jump with and without a link register.
        step(1'b0, 1'b0, 1'b0, jal1, 32'h200, 32'h0, 32'h0);
        chk1("jal_pred", pred_taken, 1'b1);
        chk32("jal_predpc", pred_pc, 32'h240);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h0, 32'h0);
        chk1("jal_mis", mispredict, 1'b0);
        chk1("jal_wr", reg_file_wr_en, 1'b1);
        chk32("jal_ret", ret_addr, 32'h204);
        step(1'b0, 1'b0, 1'b0, jal0, 32'h200, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h0, 32'h0);
        chk1("jal_rd0_wr", reg_file_wr_en, 1'b0);

        // Register jump mispredicts; the instruction behind it is squashed.
        step(1'b0, 1'b0, 1'b0, jr, 32'h300, 32'h0, 32'h0);
        chk1("jr_pred", pred_taken, 1'b0);
        step(1'b0, 1'b0, 1'b0, jal2, 32'h304, 32'h4000, 32'h0);
        chk1("jr_mis", mispredict, 1'b1);
        chk32("jr_newpc", new_pc, 32'h4000);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h0, 32'h0);
        chk1("squash_wr", reg_file_wr_en, 1'b0);
        chk1("squash_mis", mispredict, 1'b0);

        // Signed vs unsigned BLT on -1 < 1.
        step(1'b0, 1'b0, 1'b0, blt, 32'h400, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'hFFFF_FFFF, 32'h1);
        chk1("blt_s_mis", mispredict, 1'b1);
        chk32("blt_s_newpc", new_pc, 32'h410);
        step(1'b0, 1'b0, 1'b0, bltu, 32'h400, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'hFFFF_FFFF, 32'h1);
        chk1("blt_u_mis", mispredict, 1'b0);

        // Stall with a mispredicting branch in ID/EX, flush ignored while stalled.
        step(1'b0, 1'b0, 1'b0, beq5, 32'h504, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, (i == 1), jal1, 32'h600, 32'h9, 32'h9);
            chk1("stall_mis", mispredict, 1'b0);
            chk1("stall_wr", reg_file_wr_en, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h9, 32'h9);
        chk1("release_mis", mispredict, 1'b1);
        chk32("release_newpc", new_pc, 32'h50C);
        step(1'b0, 1'b0, 1'b0, beq5, 32'h504, 32'h0, 32'h0);
        chk1("release_once", mispredict, 1'b0);
        chk1("stall_ctr2_pred", pred_taken, 1'b1);
        step(1'b0, 1'b0, 1'b0, nop_i, 32'h0, 32'h1, 32'h2);
        chk1("stall_nt_mis", mispredict, 1'b1);
        step(1'b0, 1'b0, 1'b0, beq5, 32'h504, 32'h0, 32'h0);
        chk1("stall_ctr1_pred", pred_taken, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            kr = int'($urandom_range(0, 9));
            rx = mk((kr < 2) ? 0 : (kr < 7) ? 1 : 2, ($urandom_range(0, 3) != 0),
                    1'($urandom()), 2'($urandom()), 5'($urandom_range(0, 3)),
                    5'($urandom()), 16'($urandom()));
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FF00 + 4 * $urandom_range(0, 63);
            else                           rpc = 4 * $urandom_range(0, 255);
            d1 = pick();
            d2 = ($urandom_range(0, 9) < 3) ? d1 : pick();
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10), rx, rpc, d1, d2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
Parametrised successor to the single-lane branch pipeline. Decode → ID/EX → execute, with a direct-mapped table of 2-bit saturating counters that predicts at decode and is updated at execute. Emits an early predicted redirect to fetch, and a late mispredict redirect with the corrected PC. Sits in the branch slot of the VLIW bundle; register-file and return-address interface is unchanged.

Parameters:
XLEN, 32, datapath/PC width
IMM_W, 22, branch immediate width from decode; sign/zero-extended to XLEN
PRED_DEPTH, 64, counter-table entries; power of 2, at least 2; index = pc[log2(PRED_DEPTH)+1:2]
CTR_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  freeze ID/EX; suppress all side effects
flush  in  1  squash the instruction entering ID/EX (external squash)
inst  in  32  instruction from instruction register
inst_pc  in  XLEN  PC of inst
pred_taken  out  1  decode-stage prediction
pred_pc  out  XLEN  predicted target (valid when pred_taken)
rs1_out  out  5  reg-file read address 1 (registered, ID/EX)
rs2_out  out  5  reg-file read address 2
rs1_data  in  XLEN  reg-file data 1
rs2_data  in  XLEN  reg-file data 2
rd_out  out  5  destination register
ret_addr  out  XLEN  link value: pc+4
reg_file_wr_en  out  1  write ret_addr to rd_out
mispredict  out  1  execute-stage redirect request
new_pc  out  XLEN  corrected PC (valid when mispredict)

Behaviour:
- Decode uses existing branch_decode fields: is_nop, is_jmp, is_imm_type, zero_ext, op, rs1, rs2, rd, imm.
- Op encoding: 0 BEQ, 1 BNE, 2 BLT, 3 BGE. BLT/BGE compare signed; unsigned when zero_ext=1.
- Target: imm-type = pc + ext(imm), modulo 2^XLEN. Register-type = rs1_data.
- Actual taken: jumps always; conditional branches per compare of rs1_data vs rs2_data.
- Decode prediction (combinational from inst and table):
  - imm-type jump: taken.
  - imm-type conditional: taken iff ctr[idx][1].
  - register-type or nop: not taken.
  - pred_pc = inst_pc + ext(imm).
  - pred_taken forced 0 during rst.
- ID/EX captures decode fields, pc, pred_taken and pred_pc each cycle when !stall.
  - Captures a nop when flush=1 or mispredict=1 in the same cycle (the wrong-path slot is squashed).
  - rst loads a nop with all fields 0.
  - stall holds the register; stall has priority over flush.
- Execute (combinational from ID/EX, qualified by !stall and !nop):
  - mispredict = (actual_taken != pred_taken) OR (actual_taken AND target != pred_pc).
  - new_pc = actual_taken ? target : pc+4.
  - reg_file_wr_en = is_jmp AND rd != 0. ret_addr = pc+4 regardless.
- Latency: prediction in cycle 0; resolution and mispredict in cycle 1, i.e. one cycle after inst is presented, absent stall.
- Counter update at the clock edge ending the execute cycle, only for non-nop conditional branches, only when !stall: taken → increment saturating at 3; not-taken → decrement saturating at 0.
- Jumps never update the table.
- Same-cycle read (decode) and write (execute) to the same index: decode sees the old value; no bypass.
- Reset: all counters to CTR_INIT; ID/EX to nop; mispredict, reg_file_wr_en, pred_taken = 0; rs*_out and rd_out = 0.
- Reset mid-operation discards the in-flight branch with no update.
- Index aliasing is permitted (no tags).

Decomposition:
- Shared package branch_pkg: op enum (BEQ/BNE/BLT/BGE), 2-bit counter typedef, CTR_INIT, saturating inc/dec functions, ID/EX struct typedef.
- Reuse branch_decode.
- One new sub-module branch_pred_table: counter array, read port, write port with update logic, synchronous reset.

Test Plan:
- Reset, then imm-type BEQ at pc=0x100, imm=0x20, rs1=rs2=5: pred_taken=0 → next cycle mispredict=1, new_pc=0x120. After the same branch commits twice more (taken each time), the counter at idx 0 equals 3 and decode pred_taken=1.
- Counter=2 (predicted taken), BNE with rs1=rs2: mispredict=1, new_pc=pc+4. Counter decrements to 1.
- Imm JAL rd=1 at pc=0x200: pred_taken=1, pred_pc=0x200+imm. Next cycle mispredict=0, reg_file_wr_en=1, ret_addr=0x204. With rd=0: reg_file_wr_en=0.
- Register jump, rs1_data=0x4000: pred_taken=0 → mispredict=1, new_pc=0x4000. The following instruction is captured as a nop (no wr_en, no update).
- BLT with rs1_data=0xFFFFFFFF, rs2_data=1: taken when zero_ext=0, not taken when zero_ext=1.
- Stall held 3 cycles with a mispredicting branch in ID/EX: mispredict stays 0 and no counter change. Mispredict fires exactly once after release. Flush with stall=1 has no effect.
